axis_packer: RTL
================

# axis_packer

Stream width up-converter. Accepts narrow beats on a valid/ready upstream port and packs `ratio` consecutive beats into one wide word on a valid/ready downstream port. It sits on the consumer side of the narrow stream FIFO (`AXI_stream_top`) and turns its narrow output into bus-width words. An upstream `last` flushes a partial word with a lane-enable mask.

## Interface
- `width`, 4: narrow beat width in bits.
- `ratio`, 4: narrow beats per wide word; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `up_valid`  in  1  narrow beat offered.
- `up_ready`  out  1  packer accepts the beat this cycle.
- `up_data`  in  `width`  narrow beat.
- `up_last`  in  1  beat is the final beat of a packet.
- `down_valid`  out  1  wide word held on the output.
- `down_ready`  in  1  sink takes the word this cycle.
- `down_data`  out  `width*ratio`  packed word; lane 0 (first beat) is in bits [`width`-1:0].
- `down_keep`  out  `ratio`  per-lane valid mask.
- `down_last`  out  1  word closes a packet.

## Operation
- The packer has two stages:
  - Accumulator: data, keep and last registers, a lane counter `lane` (`$clog2(ratio)` bits), and a flag `acc_full`.
  - Output register: drives the `down_*` ports.
- A transfer occurs on a side when its valid and ready are both 1 on a rising edge.
- `up_ready` = `rst` deasserted AND NOT `acc_full`. It is fully registered and does not depend combinationally on `down_ready`.
- On an upstream transfer:
  - Write `up_data` into lane `lane` and set `keep[lane]`.
  - The word is complete when `lane == ratio-1` or `up_last == 1`.
  - Not complete: `lane` increments.
  - Complete: `lane` wraps to 0 and the word is handed off as described below.
- Hand-off. The output is free when `down_valid == 0`, or when a downstream transfer happens in the same cycle.
  - Completed word and output free: move accumulator data, keep and last to the output register; set `down_valid`; clear the accumulator.
  - Completed word and output not free: set `acc_full`. The word moves on the first later cycle in which the output is free, and `acc_full` clears on that same edge.
- Cleared accumulator: data = 0, keep = 0, last = 0. Lanes not written in a flushed partial word output data 0 and keep 0.
- A downstream transfer with no word waiting in the accumulator clears `down_valid`.
- `down_data`, `down_keep` and `down_last` are stable while `down_valid == 1 && down_ready == 0`.
- Simultaneous events (upstream transfer completing a word, plus a downstream transfer of the previous word in the same cycle): the new word loads into the output register and `down_valid` stays 1. This sustains full narrow-side throughput.
- While `acc_full == 1` no upstream beats are accepted, so the lane-0 write of the next word cannot collide with the waiting word.

## Timing
- Reset values, held asynchronously while `rst == 0`:
  - `up_ready` = 0
  - `down_valid` = 0
  - `down_data` = 0
  - `down_keep` = 0
  - `down_last` = 0
  - `lane` = 0
  - `acc_full` = 0
- `up_ready` rises on the first clock edge after reset deasserts.
- Latency: `down_valid` rises 1 cycle after the transfer of the completing beat, when the output is free.
- Throughput: 1 narrow beat per cycle with `down_ready` held at 1. A wide word leaves every `ratio` cycles.
- Backpressure: with `down_ready == 0`, the packer accepts exactly 2·`ratio` beats (fewer if `up_last` flushes early words), then holds `up_ready` at 0.
- Reset mid-packet: the partial word and any held words are discarded. No output appears for them.

## Structure
- Package `axis_pkg`: lane-index width function `$clog2(ratio)` and a packed struct typedef {data, keep, last} parameterised by `width` and `ratio`. Both accumulator and output register use this struct.
- Sub-module `axis_out_reg`: one-entry valid/ready register slice with load, take, `down_valid` and held payload. The top holds the lane counter, the `acc_full` logic and the lane write decode.

## Test plan
- Back-to-back: `down_ready` = 1; send beats 1, 2, 3, 4, 5, 6, 7, 8 with no `up_last` -> `down_data` = 16'h4321 then 16'h8765, keep 4'hF, last 0; `up_ready` never drops.
- Partial flush: send beats A, B with `up_last` = 1 on B -> `down_data` = 16'h00BA, keep 4'b0011, last 1; the next word starts at lane 0.
- Backpressure: `down_ready` = 0; offer 10 beats continuously -> 8 accepted, then `up_ready` = 0. Raise `down_ready` -> words 16'h4321 and 16'h8765 in order, then beats 9 and 10 resume.
- Single-beat packet: beat C with `up_last` = 1 -> `down_data` = 16'h000C, keep 4'b0001, last 1, 1 cycle after acceptance.
- Reset mid-packet: after 2 beats are accepted, pulse `rst` low -> outputs return to reset values and `up_ready` = 0; after release, 4 new beats produce exactly one word with keep 4'hF.
- Random `up_valid`/`down_ready` for 200 cycles -> a scoreboard queue model reports no mismatches and no leftover data.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the axis_packer width up-converter.
//   AXIS_WIDTH / AXIS_RATIO : default narrow beat width and beats per wide word
//   lane_bits()             : width of the lane index for a given ratio
//   axis_word_t             : wide word payload {data, keep, last}, used by both
//                             the accumulator and the output register
package axis_pkg;

  localparam int unsigned AXIS_WIDTH = 4;
  localparam int unsigned AXIS_RATIO = 4;

  function automatic int unsigned lane_bits(input int unsigned r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

  typedef struct packed {
    logic [AXIS_WIDTH*AXIS_RATIO-1:0] data;
    logic [AXIS_RATIO-1:0]            keep;
    logic                             last;
  } axis_word_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready register slice holding a packed wide word.
//   clk, rst     : clock, asynchronous active-low reset
//   load         : capture load_word and present it (overrides take)
//   load_word    : payload to capture
//   down_ready   : sink takes the held word this cycle
//   down_valid   : a word is held on the output
//   free         : slot can accept a load this cycle (empty or being taken)
//   word         : held payload, stable while down_valid && !down_ready
module axis_out_reg
  import axis_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  axis_word_t load_word,
  input  logic       down_ready,
  output logic       down_valid,
  output logic       free,
  output axis_word_t word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      down_valid <= 1'b0;
      word       <= '0;
    end else if (load) begin
      down_valid <= 1'b1;
      word       <= load_word;
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

  assign free = !down_valid || down_ready;

endmodule

// File: rtl/axis_packer.sv
// Stream width up-converter: packs `ratio` narrow beats into one wide word.
// An upstream last flushes a partial word; unwritten lanes carry data 0, keep 0.
//   clk, rst                   : clock, asynchronous active-low reset
//   up_valid/up_ready/up_data  : narrow input stream, up_last closes a packet
//   down_valid/down_ready      : wide output stream
//   down_data                  : packed word, lane 0 (first beat) in the LSBs
//   down_keep                  : per-lane valid mask
//   down_last                  : word closes a packet
module axis_packer
  import axis_pkg::*;
#(
  parameter int unsigned width = AXIS_WIDTH,
  parameter int unsigned ratio = AXIS_RATIO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [width-1:0]       up_data,
  input  logic                   up_last,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic [width*ratio-1:0] down_data,
  output logic [ratio-1:0]       down_keep,
  output logic                   down_last
);

  localparam int unsigned LW = lane_bits(ratio);

  // The shared payload struct is sized from the package geometry.
  if (width != AXIS_WIDTH || ratio != AXIS_RATIO) begin : g_geom_check
    $error("axis_packer geometry must match axis_pkg AXIS_WIDTH/AXIS_RATIO");
  end

  logic [LW-1:0] lane;
  logic          acc_full;
  logic          run;
  axis_word_t    acc;
  axis_word_t    acc_wr;
  axis_word_t    out_word;
  logic          up_fire;
  logic          word_done;
  logic          out_free;
  logic          load;

  // up_ready comes only from flops; run rises on the first edge after reset.
  assign up_ready  = run && !acc_full;
  assign up_fire   = up_valid && up_ready;
  assign word_done = up_fire && ((lane == LW'(ratio - 1)) || up_last);
  // A waiting word (acc_full) never coincides with an upstream beat, so the
  // same payload path serves both the direct hand-off and the deferred one.
  assign load      = out_free && (word_done || acc_full);

  always_comb begin
    acc_wr = acc;
    if (up_fire) begin
      for (int unsigned i = 0; i < ratio; i++) begin
        if (lane == LW'(i)) begin
          acc_wr.data[i*width +: width] = up_data;
          acc_wr.keep[i]                = 1'b1;
        end
      end
      acc_wr.last = up_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      lane     <= '0;
      acc_full <= 1'b0;
      acc      <= '0;
    end else begin
      run <= 1'b1;
      if (up_fire) begin
        lane <= word_done ? '0 : lane + LW'(1);
      end
      acc <= load ? '0 : acc_wr;
      if (word_done && !out_free) begin
        acc_full <= 1'b1;
      end else if (acc_full && out_free) begin
        acc_full <= 1'b0;
      end
    end
  end

  axis_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (acc_wr),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .free       (out_free),
    .word       (out_word)
  );

  assign down_data = out_word.data;
  assign down_keep = out_word.keep;
  assign down_last = out_word.last;

endmodule
